// File: rtl/mul_seq_pkg.sv
// Shared types for the multiplier operand sequencer: FSM states, default
// sizing, and which operand each state drives onto the multiplier bus.
package mul_seq_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_MAX_WAIT = 70000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_RESULT
    } state_t;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_A,
        SEL_B
    } data_sel_t;

    function automatic data_sel_t data_sel(state_t s);
        case (s)
            S_START, S_LOAD_A: return SEL_A;
            S_LOAD_B, S_WAIT:  return SEL_B;
            default:           return SEL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/mul_operand_sequencer_wdog.sv
// Watchdog for the WAIT state: cleared just before WAIT is entered, counts
// once per WAIT cycle, and flags the last permitted cycle.
module mul_wdog
    import mul_seq_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && !expired)
            count <= count + CW'(1);
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/mul_operand_sequencer.sv
// Feeds an operand pair to the shared-bus shift/add multiplier (start, A, B),
// waits for done under a watchdog, and hands the product downstream.
module mul_operand_sequencer
    import mul_seq_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_data,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_product,
    output logic             mul_clr,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err
);

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] op_a, op_b;
    logic             accept, zero_op, expired;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_ready && in_valid;
    assign zero_op  = (a_in == '0) || (b_in == '0);

    // On the accept edge the operand registers are not loaded yet, so the
    // first bus value comes straight from the input port.
    assign op_a = (state == S_IDLE) ? a_in : a_q;
    assign op_b = (state == S_IDLE) ? b_in : b_q;

    mul_wdog #(.MAX_WAIT(MAX_WAIT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == S_LOAD_B),
        .en      (state == S_WAIT),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (accept) state_n = zero_op ? S_RESULT : S_START;
            S_START:  state_n = S_LOAD_A;
            S_LOAD_A: state_n = S_LOAD_B;
            S_LOAD_B: state_n = S_WAIT;
            S_WAIT:   if (mul_done || expired) state_n = S_RESULT;
            S_RESULT: if (res_ready) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_start <= 1'b0;
            mul_clr   <= 1'b0;
            res_valid <= 1'b0;
            mul_data  <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            mul_start <= (state_n == S_START);
            mul_clr   <= (state == S_WAIT) && (state_n == S_RESULT);
            res_valid <= (state_n == S_RESULT);
            case (data_sel(state_n))
                SEL_A:   mul_data <= op_a;
                SEL_B:   mul_data <= op_b;
                default: mul_data <= '0;
            endcase
            if (accept) begin
                a_q <= a_in;
                b_q <= b_in;
                if (zero_op) begin
                    res_data <= '0;
                    res_err  <= 1'b0;
                end
            end
            // Done takes priority over a coincident timeout.
            if (state == S_WAIT) begin
                if (mul_done) begin
                    res_data <= mul_product;
                    res_err  <= 1'b0;
                end else if (expired) begin
                    res_data <= '0;
                    res_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Directed bench for mul_operand_sequencer with MAX_WAIT = 16.
module tb_mul_operand_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         mul_start;
    logic [W-1:0] mul_data;
    logic         mul_done = 1'b0;
    logic [W-1:0] mul_product = '0;
    logic         mul_clr;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic         res_err;

    int errors = 0;
    int checks = 0;
    int n_start = 0;
    int n_clr = 0;

    mul_operand_sequencer #(.WIDTH(W), .MAX_WAIT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .mul_start   (mul_start),
        .mul_data    (mul_data),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .mul_clr     (mul_clr),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_err     (res_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mul_start) n_start++;
        if (mul_clr) n_clr++;
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_start", 32'(mul_start), 0);
        chk("rst_clr",   32'(mul_clr),   0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_err",   32'(res_err),   0);
        chk("rst_rdata", 32'(res_data),  0);
        chk("rst_mdata", 32'(mul_data),  0);
        tick();
        #3 rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 1);

        // 7 x 6 with done after 10 WAIT cycles
        a_in = 7; b_in = 6; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_start",   32'(mul_start), 1);
        chk("t1_data0",   32'(mul_data),  7);
        chk("t1_inready", 32'(in_ready),  0);
        tick();
        chk("t1_start_lo", 32'(mul_start), 0);
        chk("t1_data1",    32'(mul_data),  7);
        tick();
        chk("t1_data2", 32'(mul_data), 6);
        tick();
        chk("t1_wait_data", 32'(mul_data), 6);
        repeat (9) tick();
        chk("t1_not_yet", 32'(res_valid), 0);
        mul_done = 1'b1; mul_product = 42;
        tick();
        mul_done = 1'b0;
        chk("t1_valid",  32'(res_valid), 1);
        chk("t1_rdata",  32'(res_data),  42);
        chk("t1_err",    32'(res_err),   0);
        chk("t1_clr",    32'(mul_clr),   1);
        chk("t1_mdata0", 32'(mul_data),  0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t1_idle_valid", 32'(res_valid), 0);
        chk("t1_idle_ready", 32'(in_ready),  1);
        chk("t1_n_start",    32'(n_start),   1);
        chk("t1_n_clr",      32'(n_clr),     1);

        // mul_done outside WAIT is ignored
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        chk("ign_done_valid", 32'(res_valid), 0);
        chk("ign_done_ready", 32'(in_ready),  1);

        // Zero-operand bypass
        a_in = 0; b_in = 9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("z_valid", 32'(res_valid), 1);
        chk("z_rdata", 32'(res_data),  0);
        chk("z_err",   32'(res_err),   0);
        chk("z_start", 32'(mul_start), 0);
        chk("z_clr",   32'(mul_clr),   0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("z_inready",  32'(in_ready), 1);
        chk("z_n_start",  32'(n_start),  1);
        chk("z_n_clr",    32'(n_clr),    1);

        // Timeout: WAIT entered at accept+4, RESULT 16 cycles later
        a_in = 5; b_in = 3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("to_wait_data", 32'(mul_data), 3);
        repeat (15) tick();
        chk("to_early", 32'(res_valid), 0);
        tick();
        chk("to_valid", 32'(res_valid), 1);
        chk("to_err",   32'(res_err),   1);
        chk("to_rdata", 32'(res_data),  0);
        chk("to_clr",   32'(mul_clr),   1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Backpressure on a real product, with a new pair waiting
        a_in = 16'h0012; b_in = 16'h0034; in_valid = 1'b1;
        tick();
        a_in = 10; b_in = 11;
        repeat (3) tick();
        mul_done = 1'b1; mul_product = 16'h03A8;
        tick();
        mul_done = 1'b0;
        chk("bp_valid0", 32'(res_valid), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_valid%0d", i + 1), 32'(res_valid), 1);
            chk($sformatf("bp_rdata%0d", i + 1), 32'(res_data), 32'h03A8);
            chk($sformatf("bp_inrdy%0d", i + 1), 32'(in_ready), 0);
            chk($sformatf("bp_clr%0d", i + 1),   32'(mul_clr),  0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp_back_idle", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("bp_next_start", 32'(mul_start), 1);
        chk("bp_next_data",  32'(mul_data),  10);
        repeat (2) tick();
        chk("bp_next_b", 32'(mul_data), 11);
        repeat (3) tick();

        // Asynchronous reset mid-WAIT
        #2 rst = 1'b1;
        #1;
        chk("mr_valid", 32'(res_valid), 0);
        chk("mr_mdata", 32'(mul_data),  0);
        chk("mr_start", 32'(mul_start), 0);
        chk("mr_clr",   32'(mul_clr),   0);
        chk("mr_rdata", 32'(res_data),  0);
        tick();
        #3 rst = 1'b0;
        tick();
        chk("mr_inready", 32'(in_ready),  1);
        chk("mr_novalid", 32'(res_valid), 0);

        // 3 x 5 with done coinciding with the last watchdog cycle
        a_in = 3; b_in = 5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("f_data0", 32'(mul_data), 3);
        repeat (3) tick();
        chk("f_data_b", 32'(mul_data), 5);
        repeat (15) tick();
        mul_done = 1'b1; mul_product = 15;
        tick();
        mul_done = 1'b0;
        chk("f_valid", 32'(res_valid), 1);
        chk("f_rdata", 32'(res_data),  15);
        chk("f_err",   32'(res_err),   0);
        chk("f_clr",   32'(mul_clr),   1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("f_idle", 32'(in_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_operand_sequencer.md
# mul_operand_sequencer

Upstream front-end for the shift/add multiplier datapath. Accepts an operand pair over a valid/ready handshake and drives the multiplier's single shared operand bus: start pulse, A, then B. Waits for the multiplier's done with a watchdog, captures the product, and presents it downstream over a second valid/ready handshake. Also issues a clear pulse so the multiplier's sticky done is released before the next operation.

## Interface
- WIDTH, 16: operand and product width; matches the multiplier bus.
- MAX_WAIT, 70000: cycles allowed in WAIT before a timeout.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept a pair.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- mul_start  output  1  start pulse to the multiplier.
- mul_data  output  WIDTH  operand bus to the multiplier.
- mul_done  input  1  multiplier done; sticky until cleared.
- mul_product  input  WIDTH  multiplier product register.
- mul_clr  output  1  one-cycle clear/restart to the multiplier.
- res_valid  output  1  result valid.
- res_ready  input  1  downstream accepts result.
- res_data  output  WIDTH  product; low WIDTH bits.
- res_err  output  1  result produced by timeout; res_data = 0.

## Operation
- FSM states: IDLE, START, LOAD_A, LOAD_B, WAIT, RESULT. Encoding is defined in the shared package.
- IDLE: in_ready = 1, with no other state asserting in_ready. On in_valid & in_ready, register A and B.
  - If A == 0 or B == 0: go to RESULT with res_data = 0, res_err = 0. The multiplier is not invoked and mul_clr is not pulsed.
  - Otherwise: go to START.
- START: mul_start = 1, mul_data = A. Next state is LOAD_A.
- LOAD_A: mul_start = 0, mul_data = A. Next state is LOAD_B.
- LOAD_B: mul_data = B. Next state is WAIT.
- WAIT: mul_data = B and the watchdog counts.
  - On mul_done: capture mul_product into res_data, res_err = 0, go to RESULT.
  - On count == MAX_WAIT-1 without mul_done: res_data = 0, res_err = 1, go to RESULT.
- RESULT: res_valid = 1.
  - mul_clr = 1 for exactly the first RESULT cycle, and only when entered from WAIT (done or timeout).
  - On res_valid & res_ready: go to IDLE.
  - res_data and res_err hold stable while res_valid = 1 and not accepted.
- mul_done asserted outside WAIT is ignored.
- mul_data = 0 in IDLE and RESULT.
- All outputs are registered.

## Timing
- Reset is asynchronous: state goes to IDLE immediately.
  - mul_start = 0, mul_clr = 0, res_valid = 0, res_err = 0, res_data = 0, mul_data = 0, watchdog = 0.
  - in_ready = 1 after reset release.
- Reset mid-operation (any state) aborts with no result. Any pending result is discarded.
- Accept edge at cycle t:
  - mul_start is high in cycle t+1.
  - A is on mul_data in t+1 and t+2.
  - B is on mul_data from t+3.
  - WAIT begins at t+4.
- mul_done sampled high at edge e gives res_valid high from e+1.
- Zero-operand bypass: res_valid high at t+1.
- Timeout: RESULT entered exactly MAX_WAIT cycles after WAIT entry.
- Watchdog clears on WAIT entry. Its width is $clog2(MAX_WAIT).
- mul_done and timeout in the same cycle: done wins, res_err = 0.
- Throughput: one operation in flight. in_ready = 0 from accept until the cycle after result handshake.
  - Back-to-back accept is possible in the cycle after res handshake, since IDLE is re-entered on that edge.

## Structure
- Package mul_seq_pkg:
  - state enum.
  - default WIDTH and MAX_WAIT constants.
  - the state-to-mul_data select encoding.
- One sub-module: mul_wdog, the watchdog counter.
  - Inputs: clk, rst, clr, en.
  - Output: expired, high when count == MAX_WAIT-1.
- The remainder (FSM, operand registers, result register) is a single module.

## Test plan
- Reset, then A=7, B=6, with mul_done model returning 42 after 10 WAIT cycles:
  - mul_start pulses once.
  - mul_data shows 7, 7, then 6.
  - res_data = 42, res_err = 0.
  - mul_clr pulses once on the first RESULT cycle.
- A=0, B=9: res_valid one cycle after accept, res_data = 0, mul_start never asserted, mul_clr never asserted.
- mul_done never asserted, MAX_WAIT = 16:
  - RESULT at WAIT entry + 16.
  - res_err = 1, res_data = 0, mul_clr pulses.
- Downstream backpressure:
  - res_ready held low 5 cycles: res_valid and res_data stable, in_ready = 0.
  - New in_valid is not accepted until after the handshake; then the next pair is accepted the next cycle.
- rst asserted mid-WAIT:
  - All outputs 0 asynchronously, no res_valid.
  - After release, a fresh A=3, B=5 (product 15) completes correctly.
